// File: rtl/axis_uart_rx_if.sv
// rtl/axis_uart_rx_if.sv - AXI-Stream style interface carrying tdata/tvalid/tready
interface axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport m_axis (
        output tdata,
        output tvalid,
        input  tready
    );

    modport s_axis (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_uart_rx.sv
// rtl/axis_uart_rx.sv - UART receiver packing frames into AXI-Stream words, optional UART_RX_PARITY_CHECK_EN
module axis_uart_rx #(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int CLOCK          = 100_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_BITS    = 0
) (
    input  logic   aclk,
    input  logic   aresetn,
    input  logic   uart_rx,
    output logic   rx_done,
    output logic   frame_err,
    output logic   overrun,
    output logic   parity_err,
    axis_if.m_axis m_axis
);

    localparam int COUNT_SPEED = CLOCK / BAUD_RATE;
    localparam int DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
    localparam int CB_W        = $clog2(COUNT_SPEED);
    localparam int BIT_W       = $clog2(DATA_BITS) + 1;
    localparam int BYTE_W      = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;
    localparam int STOP_W      = $clog2(STOP_BITS) + 1;

    localparam logic [CB_W-1:0]   LP_HALF      = CB_W'(COUNT_SPEED / 2 - 1);
    localparam logic [CB_W-1:0]   LP_FULL      = CB_W'(COUNT_SPEED - 1);
    localparam logic [BIT_W-1:0]  LP_LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BYTE_W-1:0] LP_LAST_BYTE = BYTE_W'(DATA_BYTE - 1);
    localparam logic [STOP_W-1:0] LP_LAST_STOP = STOP_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    r_state;
    logic                      r_rx_meta;
    logic                      r_rx_s;
    logic                      r_rx_prev;
    logic [CB_W-1:0]           r_count_baud;
    logic [BIT_W-1:0]          r_count_bit;
    logic [BYTE_W-1:0]         r_count_byte;
    logic [STOP_W-1:0]         r_count_stop;
    logic [DATA_BITS-1:0]      r_shift;
    logic [AXI_DATA_WIDTH-1:0] r_asm;
    logic                      r_word_done;
    logic [AXI_DATA_WIDTH-1:0] r_tdata;
    logic                      r_tvalid;
    logic                      r_rx_done;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic w_baud_hit;
    logic w_tready;

    assign w_baud_hit = (r_count_baud == LP_FULL);
    assign w_tready   = m_axis.tready;

`ifdef UART_RX_PARITY_CHECK_EN
    logic r_parity_err;
    logic r_par_bad;
    logic w_par_exp;

    assign w_par_exp  = (PARITY_BITS != 0) ? (^r_shift) : ~(^r_shift);
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_count_baud <= '0;
            r_count_bit  <= '0;
            r_count_byte <= '0;
            r_count_stop <= '0;
            r_shift      <= '0;
            r_asm        <= '0;
            r_word_done  <= 1'b0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_rx_meta   <= uart_rx;
            r_rx_s      <= r_rx_meta;
            r_rx_prev   <= r_rx_s;
            r_word_done <= 1'b0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif

            if (r_tvalid && w_tready) begin
                r_tvalid <= 1'b0;
            end

            // A completed word is delivered one cycle after its final stop sample.
            if (r_word_done) begin
`ifdef UART_RX_PARITY_CHECK_EN
                if (r_par_bad) begin
                    r_parity_err <= 1'b1;
                    r_par_bad    <= 1'b0;
                end else
`endif
                if (!r_tvalid || w_tready) begin
                    r_tdata   <= r_asm;
                    r_tvalid  <= 1'b1;
                    r_rx_done <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state      <= S_START;
                        r_count_baud <= '0;
                    end
                end

                S_START: begin
                    if (r_count_baud == LP_HALF) begin
                        r_count_baud <= '0;
                        r_count_bit  <= '0;
                        r_state      <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_count_baud <= r_count_baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_baud_hit) begin
                        r_count_baud <= '0;
                        r_shift      <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_count_bit == LP_LAST_BIT) begin
                            r_count_bit <= '0;
                            r_state     <= S_PARITY;
                        end else begin
                            r_count_bit <= r_count_bit + 1'b1;
                        end
                    end else begin
                        r_count_baud <= r_count_baud + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (w_baud_hit) begin
                        r_count_baud <= '0;
                        r_count_stop <= '0;
                        r_state      <= S_STOP;
`ifdef UART_RX_PARITY_CHECK_EN
                        if (r_rx_s != w_par_exp) begin
                            r_par_bad <= 1'b1;
                        end
`endif
                    end else begin
                        r_count_baud <= r_count_baud + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_baud_hit) begin
                        r_count_baud <= '0;
                        if (!r_rx_s) begin
                            // Framing error throws away the whole partial word.
                            r_frame_err  <= 1'b1;
                            r_count_byte <= '0;
                            r_count_stop <= '0;
                            r_state      <= S_IDLE;
`ifdef UART_RX_PARITY_CHECK_EN
                            r_par_bad    <= 1'b0;
`endif
                        end else if (r_count_stop == LP_LAST_STOP) begin
                            r_count_stop <= '0;
                            r_state      <= S_IDLE;
                            for (int i = 0; i < DATA_BYTE; i++) begin
                                if (r_count_byte == BYTE_W'(i)) begin
                                    r_asm[AXI_DATA_WIDTH-1-i*DATA_BITS -: DATA_BITS] <= r_shift;
                                end
                            end
                            if (r_count_byte == LP_LAST_BYTE) begin
                                r_count_byte <= '0;
                                r_word_done  <= 1'b1;
                            end else begin
                                r_count_byte <= r_count_byte + 1'b1;
                            end
                        end else begin
                            r_count_stop <= r_count_stop + 1'b1;
                        end
                    end else begin
                        r_count_baud <= r_count_baud + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign rx_done       = r_rx_done;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_axis_uart_rx.sv
// tb/tb_axis_uart_rx.sv - directed bench for axis_uart_rx in 8-bit and 16-bit word configurations
module tb_axis_uart_rx;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic rx8     = 1'b1;
    logic rx16    = 1'b1;
    logic done8, ferr8, ovr8, perr8;
    logic done16, ferr16, ovr16, perr16;

    axis_if #(.DATA_WIDTH(8))  ax8 ();
    axis_if #(.DATA_WIDTH(16)) ax16 ();

    always #5 aclk = ~aclk;

    axis_uart_rx #(
        .AXI_DATA_WIDTH(8), .CLOCK(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
    ) u_dut8 (
        .aclk(aclk), .aresetn(aresetn), .uart_rx(rx8),
        .rx_done(done8), .frame_err(ferr8), .overrun(ovr8), .parity_err(perr8),
        .m_axis(ax8)
    );

    axis_uart_rx #(
        .AXI_DATA_WIDTH(16), .CLOCK(1_000_000), .BAUD_RATE(100_000),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
    ) u_dut16 (
        .aclk(aclk), .aresetn(aresetn), .uart_rx(rx16),
        .rx_done(done16), .frame_err(ferr16), .overrun(ovr16), .parity_err(perr16),
        .m_axis(ax16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_done8  = 0;
    int n_done8 = 0, n_ferr8 = 0, n_ovr8 = 0, n_perr8 = 0, n_xfer8 = 0;
    int n_done16 = 0, n_ferr16 = 0, n_xfer16 = 0;
    logic [7:0]  last8  = '0;
    logic [15:0] last16 = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (done8) begin
            n_done8 = n_done8 + 1;
            t_done8 = cyc;
        end
        if (ferr8)  n_ferr8  = n_ferr8 + 1;
        if (ovr8)   n_ovr8   = n_ovr8 + 1;
        if (perr8)  n_perr8  = n_perr8 + 1;
        if (done16) n_done16 = n_done16 + 1;
        if (ferr16) n_ferr16 = n_ferr16 + 1;
        if (ax8.tvalid && ax8.tready) begin
            n_xfer8 = n_xfer8 + 1;
            last8   = ax8.tdata;
        end
        if (ax16.tvalid && ax16.tready) begin
            n_xfer16 = n_xfer16 + 1;
            last16   = ax16.tdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx16 = v;
        else     rx8  = v;
    endtask

    task automatic send_bit(input bit sel, input logic v);
        set_line(sel, v);
        tick(10);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic par, input logic stp);
        t_start = cyc;
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        send_bit(sel, par);
        send_bit(sel, stp);
        set_line(sel, 1'b1);
        tick(20);
    endtask

    int b_done, b_ferr, b_xfer, b_ovr, b_perr, lat;

    initial begin
        ax8.tready  = 1'b1;
        ax16.tready = 1'b1;
        tick(3);
        check("rst_tvalid8", ax8.tvalid, 0);
        check("rst_tdata8", ax8.tdata, 0);
        check("rst_pulses8", {done8, ferr8, ovr8, perr8}, 0);
        check("rst_tvalid16", ax16.tvalid, 0);
        check("rst_tdata16", ax16.tdata, 0);
        aresetn = 1'b1;
        tick(5);

        b_done = n_done8; b_ferr = n_ferr8;
        send_frame(0, 8'hA5, 1'b1, 1'b1);
        lat = t_done8 - t_start;
        check("a5_done", n_done8 - b_done, 1);
        check("a5_data", last8, 8'hA5);
        check("a5_latency_ok", (lat >= 106 && lat <= 112), 1);
        check("a5_no_ferr", n_ferr8 - b_ferr, 0);
        check("a5_tvalid_drop", ax8.tvalid, 0);

        b_done = n_done16; b_xfer = n_xfer16;
        send_frame(1, 8'h12, 1'b1, 1'b1);
        check("w16_partial_done", n_done16 - b_done, 0);
        check("w16_partial_tvalid", ax16.tvalid, 0);
        tick(30);
        send_frame(1, 8'h34, 1'b0, 1'b1);
        check("w16_done", n_done16 - b_done, 1);
        check("w16_xfer", n_xfer16 - b_xfer, 1);
        check("w16_data", last16, 16'h1234);
        check("w16_no_ferr", n_ferr16, 0);

        b_done = n_done8; b_ferr = n_ferr8; b_xfer = n_xfer8;
        rx8 = 1'b0;
        tick(3);
        rx8 = 1'b1;
        tick(200);
        check("glitch_done", n_done8 - b_done, 0);
        check("glitch_ferr", n_ferr8 - b_ferr, 0);
        check("glitch_xfer", n_xfer8 - b_xfer, 0);

        send_frame(0, 8'h55, 1'b1, 1'b0);
        check("ferr_pulse", n_ferr8 - b_ferr, 1);
        check("ferr_no_done", n_done8 - b_done, 0);
        check("ferr_no_tvalid", ax8.tvalid, 0);
        send_frame(0, 8'h0F, 1'b1, 1'b1);
        check("after_ferr_done", n_done8 - b_done, 1);
        check("after_ferr_data", last8, 8'h0F);

        b_done = n_done8; b_ovr = n_ovr8; b_xfer = n_xfer8;
        ax8.tready = 1'b0;
        send_frame(0, 8'h11, 1'b1, 1'b1);
        check("ovr_first_tvalid", ax8.tvalid, 1);
        check("ovr_first_tdata", ax8.tdata, 8'h11);
        send_frame(0, 8'h22, 1'b1, 1'b1);
        check("ovr_hold_tdata", ax8.tdata, 8'h11);
        check("ovr_pulse", n_ovr8 - b_ovr, 1);
        check("ovr_done_count", n_done8 - b_done, 1);
        ax8.tready = 1'b1;
        tick(3);
        check("ovr_xfer", n_xfer8 - b_xfer, 1);
        check("ovr_xfer_data", last8, 8'h11);
        check("ovr_tvalid_drop", ax8.tvalid, 0);

        b_done = n_done8; b_perr = n_perr8;
        send_frame(0, 8'h01, 1'b1, 1'b1);
`ifdef UART_RX_PARITY_CHECK_EN
        check("par_err_pulse", n_perr8 - b_perr, 1);
        check("par_no_done", n_done8 - b_done, 0);
        check("par_no_tvalid", ax8.tvalid, 0);
`else
        check("par_ignored_done", n_done8 - b_done, 1);
        check("par_ignored_data", last8, 8'h01);
        check("par_err_tied", n_perr8 - b_perr, 0);
`endif

        ax8.tready = 1'b0;
        send_frame(0, 8'h77, 1'b1, 1'b1);
        check("pre_rst_tvalid", ax8.tvalid, 1);
        check("pre_rst_tdata", ax8.tdata, 8'h77);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        #3;
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", ax8.tvalid, 0);
        check("midrst_tdata", ax8.tdata, 0);
        check("midrst_pulses", {done8, ferr8, ovr8, perr8}, 0);
        rx8 = 1'b1;
        tick(2);
        aresetn = 1'b1;
        tick(20);
        ax8.tready = 1'b1;
        b_done = n_done8;
        send_frame(0, 8'h3C, 1'b1, 1'b1);
        check("post_rst_done", n_done8 - b_done, 1);
        check("post_rst_data", last8, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_uart_rx.md
Name: axis_uart_rx

Overview:
UART receiver that deserialises frames from the `uart_rx` line and presents them as AXI-Stream master words. It is the receive-side counterpart of `axis_uart_tx`, with an identical frame format (start, data LSB-first, parity, stop), and feeds downstream stream logic. When AXI_DATA_WIDTH is greater than DATA_BITS, several consecutive frames are packed into one word, first frame in the MSBs.

Parameters:
AXI_DATA_WIDTH, 8, tdata width; integer multiple of DATA_BITS
CLOCK, 100_000_000, aclk frequency in Hz
BAUD_RATE, 115_200, line rate; COUNT_SPEED = CLOCK/BAUD_RATE clocks per bit
DATA_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits per frame
PARITY_BITS, 0, parity type: 1 = bit equals XOR of data (even), 0 = inverted XOR (odd); a parity bit is always present

Ports:
aclk  in  1  clock
aresetn  in  1  reset; one clock; reset is asynchronous and active-low
uart_rx  in  1  serial line, idle high, asynchronous to aclk
rx_done  out  1  one-cycle pulse when a complete word is loaded into the output register
frame_err  out  1  one-cycle pulse when a stop-bit sample reads 0
overrun  out  1  one-cycle pulse when a completed word is dropped because tvalid is still high
parity_err  out  1  one-cycle pulse on parity mismatch (only with the macro, else tied 0)
m_axis  axis_if.m_axis  -  tdata[AXI_DATA_WIDTH], tvalid out; tready in

Behaviour:
- Reset (async assert, sync release) values:
  - outputs: tvalid=0, tdata=0, rx_done/frame_err/overrun/parity_err=0
  - FSM=IDLE; all counters 0; synchroniser flops=1.
- uart_rx passes through a 2-flop synchroniser; all logic uses the synchronised value (rx_s).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On rx_s falling edge (previous 1, current 0) -> START, count_baud=0.
- START:
  - Count to COUNT_SPEED/2-1 (integer division), then sample rx_s.
  - Sample 0 -> DATA, count_baud=0.
  - Sample 1 (glitch) -> IDLE; byte counter unchanged.
- DATA:
  - Sample at count_baud==COUNT_SPEED-1, which lands at mid-bit.
  - Bit k goes to byte bit k.
  - After DATA_BITS samples -> PARITY.
- PARITY:
  - One sample at mid-bit, stored -> STOP.
- STOP:
  - STOP_BITS samples at mid-bit.
  - Any stop sample = 0: frame_err pulse, partial word discarded (byte counter=0), -> IDLE.
  - All stop samples = 1, byte stored at tdata slot [AXI_DATA_WIDTH-1-count_byte*DATA_BITS -: DATA_BITS]:
    - If not the last byte: count_byte+1, -> IDLE to await the next start bit.
    - If last byte: word complete, count_byte=0, -> IDLE.
- Word completion, in the cycle after the final stop sample:
  - If tvalid==0 or (tvalid && tready): load assembly register into tdata, tvalid=1, rx_done pulse.
  - Otherwise: word dropped, overrun pulse, tdata/tvalid unchanged.
- Output handshake:
  - tvalid/tdata remain stable until a tvalid && tready transfer.
  - After a transfer with no new word loaded, tvalid=0 next cycle.
  - tready has no effect on receive timing; the receiver never stalls the line.
- No inter-frame timeout: a partially packed word persists in IDLE until completed, a framing error occurs, or reset.
- Reset mid-frame aborts the frame and any partial word immediately.
- Counter widths:
  - count_baud: $clog2(COUNT_SPEED)
  - count_bit: $clog2(DATA_BITS) + 1
  - count_byte: max(1, $clog2(DATA_BYTE))
- No wrap beyond terminal counts.

Optional Feature:
UART_RX_PARITY_CHECK_EN
- Defined:
  - Received parity is compared with the PARITY_BITS rule per byte.
  - Any mismatch flags the word; at completion the word is discarded (no tvalid, no rx_done) and parity_err pulses one cycle.
  - Mismatch on an intermediate byte still continues reception of the remaining bytes, then discards.
- Undefined: parity bit is sampled and ignored; parity_err tied 0.

Test Plan:
Bench parameters: CLOCK=1_000_000, BAUD_RATE=100_000 (10 clocks/bit), tready=1 unless stated.
- Frame 0xA5, parity=1 (odd), one stop bit, PARITY_BITS=0 -> tdata=0xA5, tvalid and rx_done within 3 clocks of the stop-bit mid-sample.
- AXI_DATA_WIDTH=16, frames 0x12 then 0x34 with a 50-clock idle gap -> single word tdata=0x1234, one rx_done.
- 3-clock low glitch on the idle line -> returns to IDLE; no tvalid, no frame_err.
- Frame 0x55 with stop bit driven 0 -> frame_err pulse, no tvalid; next good frame 0x0F -> tdata=0x0F.
- tready=0, two frames 0x11, 0x22 -> tdata stays 0x11, overrun pulse on second; raise tready -> transfer 0x11, tvalid drops.
- With UART_RX_PARITY_CHECK_EN, frame 0x01 with wrong parity -> parity_err pulse, no tvalid. Without the macro -> tdata=0x01 delivered.
- aresetn pulsed low mid-DATA -> all outputs at reset values immediately; next frame 0x3C received correctly.
